// File: rtl/rrf_alloc_ctrl.sv
// Rename-register-file allocator and commit-pointer tracker for the dispatch stage.
// Hands out up to two RRF tags per cycle from a circular buffer, advances the in-order commit
// pointer and keeps the free-entry count.
// Optional mispredict rollback is compiled in when RRF_ALLOC_ROLLBACK_EN is defined.
module rrf_alloc_ctrl #(
  parameter int unsigned RRF_NUM = 64,
  parameter int unsigned RRF_SEL = 6
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req1_en_i,
  input  logic               req2_en_i,
  input  logic               stall_i,
  output logic               allocatable_o,
  output logic               alloc_en1_o,
  output logic [RRF_SEL-1:0] alloc_rrftag1_o,
  output logic               alloc_en2_o,
  output logic [RRF_SEL-1:0] alloc_rrftag2_o,
  input  logic               com1_en_i,
  input  logic               com2_en_i,
  output logic [RRF_SEL-1:0] comtag1_o,
  output logic [RRF_SEL-1:0] comtag2_o,
  output logic [RRF_SEL:0]   freenum_o,
  output logic [RRF_SEL-1:0] rrfptr_o,
  output logic               rrfphase_o
`ifdef RRF_ALLOC_ROLLBACK_EN
  ,
  input  logic               rollback_i,
  input  logic [RRF_SEL-1:0] rollback_rrfptr_i
`endif
);

  localparam int unsigned FreeW = RRF_SEL + 1;
  localparam logic [RRF_SEL:0] RrfNumW = FreeW'(RRF_NUM);

  logic [RRF_SEL-1:0] rrfptr_q, rrfptr_d;
  logic [RRF_SEL-1:0] comptr_q, comptr_d;
  logic [RRF_SEL:0]   freenum_q, freenum_d;
  logic               rrfphase_q, rrfphase_d;

  logic [1:0]         reqnum;
  logic [1:0]         granted;
  logic [1:0]         comnum;
  logic               go;
  logic [RRF_SEL:0]   rrf_sum;
  logic [RRF_SEL:0]   com_sum;

`ifdef RRF_ALLOC_ROLLBACK_EN
  // Phase of the commit pointer; the reference for rebuilding rrfphase after a rollback.
  logic               comphase_q, comphase_d;
  logic [RRF_SEL-1:0] rb_dist;
`endif

  // Grant decision: purely from registered state, so same-cycle commits do not help.
  always_comb begin
    reqnum        = {1'b0, req1_en_i} + {1'b0, req2_en_i};
    allocatable_o = (freenum_q >= {{(RRF_SEL-1){1'b0}}, reqnum});
`ifdef RRF_ALLOC_ROLLBACK_EN
    go            = allocatable_o & ~stall_i & ~rollback_i;
`else
    go            = allocatable_o & ~stall_i;
`endif
    alloc_en1_o     = go & req1_en_i;
    alloc_en2_o     = go & req2_en_i;
    alloc_rrftag1_o = rrfptr_q;
    // A lone slot-2 request takes rrfptr itself.
    alloc_rrftag2_o = rrfptr_q + {{(RRF_SEL-1){1'b0}}, req1_en_i};
    granted         = {1'b0, alloc_en1_o} + {1'b0, alloc_en2_o};
    comnum          = {1'b0, com1_en_i} + {1'b0, com2_en_i};
  end

  // Next-state for pointers, phase and free count.
  always_comb begin
    rrf_sum    = {1'b0, rrfptr_q} + {{(RRF_SEL-1){1'b0}}, granted};
    com_sum    = {1'b0, comptr_q} + {{(RRF_SEL-1){1'b0}}, comnum};
    rrfptr_d   = rrf_sum[RRF_SEL-1:0];
    comptr_d   = com_sum[RRF_SEL-1:0];
    // Carry out of the pointer add marks a wrap past RRF_NUM-1.
    rrfphase_d = rrfphase_q ^ rrf_sum[RRF_SEL];
    freenum_d  = freenum_q - {{(RRF_SEL-1){1'b0}}, granted}
                           + {{(RRF_SEL-1){1'b0}}, comnum};
`ifdef RRF_ALLOC_ROLLBACK_EN
    comphase_d = comphase_q ^ com_sum[RRF_SEL];
    rb_dist    = rollback_rrfptr_i - comptr_d;
    if (rollback_i) begin
      // Live window becomes [comptr_next, target); target behind comptr means it wrapped.
      rrfptr_d   = rollback_rrfptr_i;
      freenum_d  = RrfNumW - {1'b0, rb_dist};
      rrfphase_d = comphase_d ^ (rollback_rrfptr_i < comptr_d);
    end
`endif
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rrfptr_q   <= '0;
      comptr_q   <= '0;
      freenum_q  <= RrfNumW;
      rrfphase_q <= 1'b0;
`ifdef RRF_ALLOC_ROLLBACK_EN
      comphase_q <= 1'b0;
`endif
    end else begin
      rrfptr_q   <= rrfptr_d;
      comptr_q   <= comptr_d;
      freenum_q  <= freenum_d;
      rrfphase_q <= rrfphase_d;
`ifdef RRF_ALLOC_ROLLBACK_EN
      comphase_q <= comphase_d;
`endif
    end
  end

  assign comtag1_o  = comptr_q;
  assign comtag2_o  = comptr_q + {{(RRF_SEL-1){1'b0}}, 1'b1};
  assign freenum_o  = freenum_q;
  assign rrfptr_o   = rrfptr_q;
  assign rrfphase_o = rrfphase_q;

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Scoreboard bench for rrf_alloc_ctrl: the driver predicts each cycle's outputs from a
// queue-of-live-tags model and pushes them; a negedge monitor pops and compares.
// Build with RRF_ALLOC_ROLLBACK_EN defined to also exercise rollback.
module tb_rrf_alloc_ctrl;
  localparam int N = 64;
  localparam int S = 6;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         req1_en_i, req2_en_i, stall_i, com1_en_i, com2_en_i;
  logic         allocatable_o, alloc_en1_o, alloc_en2_o, rrfphase_o;
  logic [S-1:0] alloc_rrftag1_o, alloc_rrftag2_o, comtag1_o, comtag2_o, rrfptr_o;
  logic [S:0]   freenum_o;
`ifdef RRF_ALLOC_ROLLBACK_EN
  logic         rollback_i;
  logic [S-1:0] rollback_rrfptr_i;
`endif

  always #5 clk_i = ~clk_i;

  rrf_alloc_ctrl #(.RRF_NUM(N), .RRF_SEL(S)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .req1_en_i       (req1_en_i),
    .req2_en_i       (req2_en_i),
    .stall_i         (stall_i),
    .allocatable_o   (allocatable_o),
    .alloc_en1_o     (alloc_en1_o),
    .alloc_rrftag1_o (alloc_rrftag1_o),
    .alloc_en2_o     (alloc_en2_o),
    .alloc_rrftag2_o (alloc_rrftag2_o),
    .com1_en_i       (com1_en_i),
    .com2_en_i       (com2_en_i),
    .comtag1_o       (comtag1_o),
    .comtag2_o       (comtag2_o),
    .freenum_o       (freenum_o),
    .rrfptr_o        (rrfptr_o),
    .rrfphase_o      (rrfphase_o)
`ifdef RRF_ALLOC_ROLLBACK_EN
    ,
    .rollback_i        (rollback_i),
    .rollback_rrfptr_i (rollback_rrfptr_i)
`endif
  );

  typedef struct {
    bit alloc;
    bit en1;
    bit en2;
    int tag1;
    int tag2;
    int comtag1;
    int comtag2;
    int freenum;
    int rrfptr;
    int phase;
  } exp_t;

  exp_t exp_q[$];
  int   live[$];       // allocated, not yet committed tags, oldest first
  int   alloc_total;   // tags handed out since reset (net of rollbacks)
  int   commit_total;  // tags committed since reset
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t predict(bit r1, bit r2, bit st, bit rb);
    exp_t e;
    bit   go;
    e.freenum = N - live.size();
    e.alloc   = (e.freenum >= (int'(r1) + int'(r2)));
    go        = e.alloc && !st && !rb;
    e.en1     = go && r1;
    e.en2     = go && r2;
    e.rrfptr  = alloc_total % N;
    e.phase   = (alloc_total / N) % 2;
    e.tag1    = e.rrfptr;
    e.tag2    = (e.rrfptr + int'(r1)) % N;
    e.comtag1 = commit_total % N;
    e.comtag2 = (commit_total + 1) % N;
    return e;
  endfunction

  task automatic model_update(exp_t e, bit c1, bit c2, bit rb, int rbptr);
    int d;
    int drop;
    for (int k = 0; k < int'(c1) + int'(c2); k++) begin
      void'(live.pop_front());
      commit_total++;
    end
    if (e.en1) begin live.push_back(alloc_total % N); alloc_total++; end
    if (e.en2) begin live.push_back(alloc_total % N); alloc_total++; end
    if (rb) begin
      d    = (rbptr - (commit_total % N) + N) % N;
      drop = live.size() - d;
      for (int k = 0; k < drop; k++) void'(live.pop_back());
      alloc_total -= drop;
    end
  endtask

  task automatic step(bit r1, bit r2, bit st, bit c1, bit c2, bit rb = 1'b0, int rbptr = 0);
    exp_t e;
    @(posedge clk_i);
    #1;
    reset_i   = 1'b1;
    req1_en_i = r1;
    req2_en_i = r2;
    stall_i   = st;
    com1_en_i = c1;
    com2_en_i = c2;
`ifdef RRF_ALLOC_ROLLBACK_EN
    rollback_i        = rb;
    rollback_rrfptr_i = S'(rbptr);
`endif
    e = predict(r1, r2, st, rb);
    exp_q.push_back(e);
    model_update(e, c1, c2, rb, rbptr);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    reset_i   = 1'b0;
    req1_en_i = 1'b0;
    req2_en_i = 1'b0;
    stall_i   = 1'b0;
    com1_en_i = 1'b0;
    com2_en_i = 1'b0;
`ifdef RRF_ALLOC_ROLLBACK_EN
    rollback_i        = 1'b0;
    rollback_rrfptr_i = '0;
`endif
    live.delete();
    alloc_total  = 0;
    commit_total = 0;
    exp_q.push_back(predict(1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Commit as much as is legal (up to two) so allocation keeps flowing.
  task automatic keep_up(bit r1, bit r2);
    step(r1, r2, 1'b0, live.size() >= 1, live.size() >= 2);
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every driven cycle presents one expected response.
  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("allocatable", int'(allocatable_o), int'(e.alloc));
      chk("alloc_en1", int'(alloc_en1_o), int'(e.en1));
      chk("alloc_en2", int'(alloc_en2_o), int'(e.en2));
      if (e.en1) chk("tag1", int'(alloc_rrftag1_o), e.tag1);
      if (e.en2) chk("tag2", int'(alloc_rrftag2_o), e.tag2);
      chk("comtag1", int'(comtag1_o), e.comtag1);
      chk("comtag2", int'(comtag2_o), e.comtag2);
      chk("freenum", int'(freenum_o), e.freenum);
      chk("rrfptr", int'(rrfptr_o), e.rrfptr);
      chk("rrfphase", int'(rrfphase_o), e.phase);
    end
  end

  // Protocol assertions on the commit interface.
  always @(posedge clk_i) begin
    if (reset_i === 1'b1) begin
      assert (!(com2_en_i && !com1_en_i)) else $error("com2 without com1");
      assert (int'(com1_en_i) + int'(com2_en_i) <= N - int'(freenum_o))
        else $error("commit count exceeds live entries");
    end
  end

  initial begin
    bit r1, r2, st, c1, c2, rb;
    int tgt;
    int live_after;
    reset_i = 1'b0;
    do_reset();

    // Wrap of both tags at 63 -> 0, then a straddling pair 63/0.
    keep_up(1'b1, 1'b0);
    for (int i = 0; i < 31; i++) keep_up(1'b1, 1'b1);
    keep_up(1'b1, 1'b1);                 // tags 63 and 0
    keep_up(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) keep_up(1'b1, 1'b1);
    keep_up(1'b1, 1'b1);                 // tags 62 and 63, phase toggles
    keep_up(1'b0, 1'b1);                 // lone slot-2 request
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // stalled

    // Fill until nearly full, then the all-or-nothing and same-cycle-commit corners.
    while (N - live.size() >= 2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    if (live.size() == N) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // freenum 1: nothing granted
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // freenum 1: single granted
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);  // freenum 0 with commits: still stalls
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // freenum 2 now: granted

    // Randomised traffic with a reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 7) == 0);
      c1 = (live.size() >= 1) && ($urandom_range(0, 2) != 0);
      c2 = c1 && (live.size() >= 2) && ($urandom_range(0, 1) != 0);
      rb = 1'b0;
      tgt = 0;
`ifdef RRF_ALLOC_ROLLBACK_EN
      if ($urandom_range(0, 31) == 0) begin
        rb = 1'b1;
        live_after = live.size() - int'(c1) - int'(c2);
        tgt = (commit_total + int'(c1) + int'(c2) + $urandom_range(0, live_after)) % N;
      end
`endif
      step(r1, r2, st, c1, c2, rb, tgt);
    end

`ifdef RRF_ALLOC_ROLLBACK_EN
    // comptr 10, rrfptr 30, roll back to 20 while committing one.
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending expectations", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
